// File: rtl/power_tx_pkg.sv
// Shared types and constants for the power-amplifier command framer.
// POWER_TX_CHECKSUM_EN (optional) adds a checksum byte before EOF.
package power_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_WAIT,
        ST_TAIL
    } state_e;

    typedef enum logic [1:0] {
        FLD_LEN,
        FLD_DATA,
        FLD_CHK,
        FLD_EOF
    } field_e;

    localparam logic [7:0] SOF_DEFAULT = 8'hC0;
    localparam logic [7:0] EOF_DEFAULT = 8'hCF;
    localparam int         LEN_W       = 4;

endpackage

// File: rtl/power_tx_edge.sv
// Two-flop level sampler with an enable and a rise or fall pulse.
// PIPE adds a register on the pulse; without it the pulse comes from the flops.
module power_tx_edge #(
    parameter bit RISE = 1'b1,
    parameter bit PIPE = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic d,
    output logic pls
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic hit;

    always_comb begin
        s1_d = s1_q;
        s2_d = s2_q;
        if (en) begin
            s1_d = d;
            s2_d = s1_q;
        end
    end

    assign hit = RISE ? (s1_q & ~s2_q) : (~s1_q & s2_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    generate
        if (PIPE) begin : g_pipe
            logic pls_q, pls_d;

            always_comb begin
                pls_d = en & hit;
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    pls_q <= 1'b0;
                end else begin
                    pls_q <= pls_d;
                end
            end

            assign pls = pls_q;
        end else begin : g_comb
            assign pls = hit;
        end
    endgenerate

endmodule

// File: rtl/power_tx_framer.sv
// Frames SOF, LEN, payload, [CHK], EOF towards the UART TX byte engine.
// Define POWER_TX_CHECKSUM_EN to send the payload checksum before EOF.
module power_tx_framer
    import power_tx_pkg::*;
#(
    parameter int         MAX_LEN  = 8,
    parameter logic [7:0] SOF_BYTE = SOF_DEFAULT,
    parameter logic [7:0] EOF_BYTE = EOF_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 send_en,
    input  logic [LEN_W-1:0]     tx_len,
    input  logic [8*MAX_LEN-1:0] tx_data,
    input  logic                 tx_ready,
    output logic                 comnd_en,
    output logic [7:0]           comnd_data,
    output logic                 send_vld,
    output logic                 send_done,
    output logic                 len_err
);

`ifdef POWER_TX_CHECKSUM_EN
    localparam field_e FLD_END = FLD_CHK;
`else
    localparam field_e FLD_END = FLD_EOF;
`endif

    state_e               state_q, state_d;
    field_e               fld_q, fld_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [LEN_W-1:0]     idx_q, idx_d;
    logic [8*MAX_LEN-1:0] data_q, data_d;
    logic                 en_q, en_d;
    logic [7:0]           byte_q, byte_d;
    logic                 vld_q, vld_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 rdy_prev_q, rdy_prev_d;
`ifdef POWER_TX_CHECKSUM_EN
    logic [7:0]           chk_q, chk_d;
`endif

    logic       req_en;
    logic       req_pls;
    logic       rdy_fall;
    logic [7:0] cur_byte;
    logic [7:0] len_byte;

    assign req_en   = (state_q == ST_IDLE) & ~tx_ready;
    assign len_byte = {{(8-LEN_W){1'b0}}, len_q};

    power_tx_edge #(.RISE(1'b1), .PIPE(1'b1)) u_req (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (req_en),
        .d     (send_en),
        .pls   (req_pls)
    );

    power_tx_edge #(.RISE(1'b0), .PIPE(1'b0)) u_rdy (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .d     (tx_ready),
        .pls   (rdy_fall)
    );

    always_comb begin
        cur_byte = 8'h00;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (idx_q == LEN_W'(i)) begin
                cur_byte = data_q[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        fld_d      = fld_q;
        len_d      = len_q;
        idx_d      = idx_q;
        data_d     = data_q;
        en_d       = 1'b0;
        byte_d     = byte_q;
        vld_d      = vld_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        rdy_prev_d = tx_ready;
`ifdef POWER_TX_CHECKSUM_EN
        chk_d      = chk_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_pls) begin
                    if (tx_len > LEN_W'(MAX_LEN)) begin
                        err_d = 1'b1;
                    end else begin
                        data_d  = tx_data;
                        len_d   = tx_len;
                        idx_d   = '0;
                        vld_d   = 1'b1;
                        state_d = ST_ARM;
`ifdef POWER_TX_CHECKSUM_EN
                        chk_d   = 8'h00;
`endif
                    end
                end
            end
            ST_ARM: begin
                // Transmitter must have been idle for two cycles.
                if (!tx_ready && !rdy_prev_q) begin
                    en_d    = 1'b1;
                    byte_d  = SOF_BYTE;
                    fld_d   = FLD_LEN;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (rdy_fall) begin
                    en_d = 1'b1;
                    case (fld_q)
                        FLD_LEN: begin
                            byte_d = len_byte;
                            idx_d  = '0;
                            fld_d  = (len_q == '0) ? FLD_END : FLD_DATA;
                        end
                        FLD_DATA: begin
                            byte_d = cur_byte;
`ifdef POWER_TX_CHECKSUM_EN
                            chk_d  = chk_q + cur_byte;
`endif
                            if (idx_q == len_q - 1'b1) begin
                                fld_d = FLD_END;
                            end else begin
                                idx_d = idx_q + 1'b1;
                            end
                        end
                        FLD_CHK: begin
`ifdef POWER_TX_CHECKSUM_EN
                            byte_d = chk_q;
                            fld_d  = FLD_EOF;
`else
                            byte_d  = EOF_BYTE;
                            state_d = ST_TAIL;
`endif
                        end
                        FLD_EOF: begin
                            byte_d  = EOF_BYTE;
                            state_d = ST_TAIL;
                        end
                        default: begin
                            en_d    = 1'b0;
                            vld_d   = 1'b0;
                            state_d = ST_IDLE;
                        end
                    endcase
                end
            end
            ST_TAIL: begin
                if (rdy_fall) begin
                    vld_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                fld_d   = FLD_LEN;
                idx_d   = '0;
                byte_d  = 8'h00;
                vld_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            fld_q      <= FLD_LEN;
            len_q      <= '0;
            idx_q      <= '0;
            data_q     <= '0;
            en_q       <= 1'b0;
            byte_q     <= 8'h00;
            vld_q      <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rdy_prev_q <= 1'b0;
`ifdef POWER_TX_CHECKSUM_EN
            chk_q      <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            fld_q      <= fld_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            en_q       <= en_d;
            byte_q     <= byte_d;
            vld_q      <= vld_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rdy_prev_q <= rdy_prev_d;
`ifdef POWER_TX_CHECKSUM_EN
            chk_q      <= chk_d;
`endif
        end
    end

    assign comnd_en   = en_q;
    assign comnd_data = byte_q;
    assign send_vld   = vld_q;
    assign send_done  = done_q;
    assign len_err    = err_q;

endmodule

// File: tb/tb_power_tx_framer.sv
// Directed bench for power_tx_framer with a busy-flag transmitter model.
// Expected frames follow POWER_TX_CHECKSUM_EN when it is defined.
`timescale 1ns/1ps
module tb_power_tx_framer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        send_en;
    logic [3:0]  tx_len;
    logic [63:0] tx_data;
    logic        tx_ready;
    logic        comnd_en;
    logic [7:0]  comnd_data;
    logic        send_vld;
    logic        send_done;
    logic        len_err;

    logic busy     = 1'b0;
    logic tx_force = 1'b0;
    int   bcnt     = 0;

    assign tx_ready = busy | tx_force;

    always #5 clk = ~clk;

    power_tx_framer #(.MAX_LEN(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .send_en    (send_en),
        .tx_len     (tx_len),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .comnd_en   (comnd_en),
        .comnd_data (comnd_data),
        .send_vld   (send_vld),
        .send_done  (send_done),
        .len_err    (len_err)
    );

    typedef struct {
        logic [3:0]  len;
        logic [63:0] data;
        logic [7:0]  chk;
        bit          mid;
    } vec_t;

    vec_t vt[5];

    int         n_chk  = 0;
    int         n_fail = 0;
    int         cyc    = 0;
    logic [7:0] sq[$];
    int         sc[$];
    int         done_n = 0;
    int         err_n  = 0;
    int         vld_n  = 0;
    logic       prev_en = 1'b0;
    logic       pend    = 1'b0;
    int         fall_cyc = 0;
    int         b_q, b_done, b_err, b_vld;
    int         rel;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model: busy for 10 cycles after each strobe.
    always @(negedge clk) begin
        if (comnd_en) begin
            chk("no_back_to_back", 32'(prev_en), 32'd0);
            if (pend) chk("fall_to_strobe", cyc - fall_cyc, 32'd2);
            sq.push_back(comnd_data);
            sc.push_back(cyc);
            pend <= 1'b0;
            busy <= 1'b1;
            bcnt <= 10;
        end else if (busy) begin
            bcnt <= bcnt - 1;
            if (bcnt == 1) begin
                busy <= 1'b0;
                if (send_vld) begin
                    pend     <= 1'b1;
                    fall_cyc <= cyc;
                end
            end
        end
        if (send_done) begin
            done_n <= done_n + 1;
            chk("fall_to_done", pend ? cyc - fall_cyc : -1, 32'd2);
            pend <= 1'b0;
        end
        if (len_err) err_n <= err_n + 1;
        if (send_vld) vld_n <= vld_n + 1;
        prev_en <= comnd_en;
    end

    task automatic start(input int vi);
        @(posedge clk);
        #1;
        b_q     = sq.size();
        b_done  = done_n;
        b_err   = err_n;
        b_vld   = vld_n;
        tx_len  = vt[vi].len;
        tx_data = vt[vi].data;
        send_en = 1'b1;
    endtask

    task automatic finish_frame(input int vi);
        logic [7:0] e[$];
        int tog  = 0;
        int tcnt = 0;
        for (int k = 0; k < 3000 && done_n == b_done; k++) begin
            @(posedge clk);
            #1;
            if (vt[vi].mid) begin
                if (tog == 0 && sq.size() - b_q >= 5) begin
                    tog     = 1;
                    send_en = 1'b0;
                    tcnt    = 3;
                end else if (tcnt > 0) begin
                    tcnt--;
                    if (tcnt == 0) send_en = 1'b1;
                end
            end
        end
        repeat (20) @(posedge clk);
        #1;
        send_en = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        e.push_back(8'hC0);
        e.push_back({4'h0, vt[vi].len});
        for (int i = 0; i < int'(vt[vi].len); i++)
            e.push_back(vt[vi].data[8*i +: 8]);
`ifdef POWER_TX_CHECKSUM_EN
        e.push_back(vt[vi].chk);
`endif
        e.push_back(8'hCF);
        chk($sformatf("v%0d_done_count", vi), done_n - b_done, 32'd1);
        chk($sformatf("v%0d_no_len_err", vi), err_n - b_err, 32'd0);
        chk($sformatf("v%0d_strobes", vi), sq.size() - b_q, e.size());
        for (int i = 0; i < e.size(); i++) begin
            if (b_q + i < sq.size())
                chk($sformatf("v%0d_byte%0d", vi, i), sq[b_q+i], e[i]);
        end
    endtask

    initial begin
        vt[0] = '{4'd3, 64'h0000_0000_0033_2211, 8'h66, 1'b0};
        vt[1] = '{4'd0, 64'h0,                   8'h00, 1'b0};
        vt[2] = '{4'd8, {8{8'hFF}},              8'hF8, 1'b1};
        vt[3] = '{4'd1, 64'h0000_0000_0000_0080, 8'h80, 1'b0};
        vt[4] = '{4'd5, 64'h0000_0005_0403_0201, 8'h0F, 1'b0};

        rst_n   = 1'b0;
        send_en = 1'b0;
        tx_len  = 4'd0;
        tx_data = 64'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_comnd_en",   32'(comnd_en),   32'd0);
        chk("reset_comnd_data", 32'(comnd_data), 32'd0);
        chk("reset_send_vld",   32'(send_vld),   32'd0);
        chk("reset_send_done",  32'(send_done),  32'd0);
        chk("reset_len_err",    32'(len_err),    32'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // Cycle-exact request latency on the first frame.
        start(0);
        repeat (2) @(posedge clk);
        #1;
        chk("vld_not_before_t3", 32'(send_vld), 32'd0);
        @(posedge clk);
        #1;
        chk("vld_at_t3", 32'(send_vld), 32'd1);
        @(posedge clk);
        #1;
        chk("sof_at_t4", {23'd0, comnd_en, comnd_data}, {23'd0, 1'b1, 8'hC0});
        finish_frame(0);

        for (int vi = 1; vi < 5; vi++) begin
            start(vi);
            finish_frame(vi);
        end

        // Oversize length is rejected.
        @(posedge clk);
        #1;
        b_q     = sq.size();
        b_err   = err_n;
        b_vld   = vld_n;
        tx_len  = 4'd9;
        send_en = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("len9_err_pulses", err_n - b_err, 32'd1);
        chk("len9_no_strobes", sq.size() - b_q, 32'd0);
        chk("len9_no_vld", vld_n - b_vld, 32'd0);
        send_en = 1'b0;
        repeat (5) @(posedge clk);

        // Reset mid-frame after the third strobe.
        start(0);
        for (int k = 0; k < 500 && sq.size() - b_q < 3; k++) begin
            @(posedge clk);
            #1;
        end
        rst_n   = 1'b0;
        send_en = 1'b0;
        @(posedge clk);
        #1;
        chk("midreset_outputs",
            {20'd0, comnd_en, comnd_data, send_vld, send_done, len_err}, 32'd0);
        rst_n = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        chk("midreset_no_eof", sq.size() - b_q, 32'd3);
        chk("midreset_no_done", done_n - b_done, 32'd0);
        start(0);
        finish_frame(0);

        // Request while the transmitter is busy.
        @(posedge clk);
        #1;
        tx_force = 1'b1;
        start(3);
        repeat (20) @(posedge clk);
        #1;
        chk("held_no_vld", vld_n - b_vld, 32'd0);
        chk("held_no_strobe", sq.size() - b_q, 32'd0);
        tx_force = 1'b0;
        rel      = cyc;
        finish_frame(3);
        if (sc.size() > b_q)
            chk("sof_after_release", sc[b_q] - rel, 32'd4);
        else
            chk("sof_after_release", 32'hFFFF_FFFF, 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/power_tx_framer.md
# power_tx_framer

Parametrised successor to the power-amplifier command serialiser. It captures one command of up to MAX_LEN payload bytes on a rising edge of `send_en`. It emits the frame SOF, LEN, payload (byte 0 first), optional checksum and EOF one byte at a time to the RS232 byte transmitter, pacing each byte on that transmitter's busy flag. The block sits between the RF-control command source and the UART TX byte engine. Over the previous fixed 3-byte serialiser it adds:
- runtime length up to MAX_LEN
- length-error rejection
- a done pulse

## Interface
Parameters:
- MAX_LEN, 8, maximum payload bytes per frame (1..15)
- SOF_BYTE, 8'hC0, start-of-frame byte
- EOF_BYTE, 8'hCF, end-of-frame byte
- LEN_W (localparam), 4, width of length field; LEN byte on the wire is zero-extended to 8 bits

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- send_en  in  1  level request; a rising edge starts one frame
- tx_len  in  LEN_W  payload byte count, 0..MAX_LEN valid
- tx_data  in  8*MAX_LEN  payload; byte i = tx_data[8i+7:8i]
- tx_ready  in  1  byte transmitter busy (high = sending); a falling edge = byte done
- comnd_en  out  1  one-cycle strobe: comnd_data valid, transmitter starts byte
- comnd_data  out  8  byte to transmit; held until the next strobe
- send_vld  out  1  high while a frame is in progress
- send_done  out  1  one-cycle pulse after the EOF byte completes
- len_err  out  1  one-cycle pulse: request rejected, tx_len > MAX_LEN

## Operation
- All outputs reset to 0. All registers clear on `rst_n` low at a clk edge, including mid-frame: the frame is abandoned and no EOF is sent.
- `send_en` passes through two sampling flops, enabled only while in IDLE and `tx_ready` low. A registered rising-edge pulse is produced from these flops.
- FSM states:
  - IDLE
    - On an edge pulse with tx_len ≤ MAX_LEN: capture tx_data/tx_len, clear checksum, set send_vld, go to ARM.
    - On an edge pulse with tx_len > MAX_LEN: pulse len_err, stay in IDLE, send_vld stays 0.
  - ARM
    - When `tx_ready` is low for the current and previous cycle: strobe SOF_BYTE, field := LEN, go to WAIT.
  - WAIT
    - On a registered `tx_ready` falling edge, strobe the next field's byte:
      - LEN → payload[0], or → CHK/EOF if len = 0
      - each payload[i] is added to the checksum as it is strobed
      - CHK → EOF
    - After the EOF falling edge: clear send_vld, pulse send_done, go to IDLE.
- Checksum: 8-bit modulo-256 sum of the payload bytes only. LEN, SOF and EOF are excluded. Length 0 gives checksum 8'h00.
- A byte index counter of LEN_W bits counts 0..len-1 and never wraps past len.
- A `send_en` edge while send_vld is high is ignored, not queued. A new frame needs send_en low, then high again, after return to IDLE.
- Illegal state encoding → IDLE with outputs cleared.

## Timing
- send_en first sampled high at cycle t (tx_ready low) → send_vld high from t+3; tx_data/tx_len are captured at the same edge and must be stable over t..t+2.
- The SOF strobe follows send_vld by ≥1 cycle: at t+4 if tx_ready has been low since t+2.
- tx_ready first low at cycle n after being high → the next comnd_en is at n+2.
- send_done is at n+2 after the EOF's falling edge; send_vld is low from the same cycle.
- comnd_en is never high on two consecutive cycles. A frame carries len+4 strobes, or len+3 without the checksum.

## Configuration
- POWER_TX_CHECKSUM_EN defined: the CHK byte is sent between the last payload byte and EOF.
- POWER_TX_CHECKSUM_EN not defined: the checksum adder and the CHK field are removed; EOF follows the last payload byte, or LEN when len = 0.

## Structure
- `power_tx_pkg`:
  - the state enum
  - the field enum (FLD_LEN, FLD_DATA, FLD_CHK, FLD_EOF)
  - the default SOF/EOF constants
- One sub-module, `power_tx_edge`: a two-flop sampler with a registered rise/fall pulse and an enable input. It is instanced for send_en (rise) and tx_ready (fall).

## Test plan
- MAX_LEN=8, tx_len=3, tx_data[23:0]=24'h332211, model transmitter busy 10 cycles per byte → strobes C0,03,11,22,33,66,CF; exactly one send_done.
- tx_len=0 → C0,00,00,CF; without POWER_TX_CHECKSUM_EN → C0,00,CF.
- tx_len=9 with MAX_LEN=8 → len_err pulses once; no comnd_en; send_vld stays 0.
- Payload 8×8'hFF, len 8 → checksum 8'hF8 (wrap); second send_en edge mid-frame is ignored, giving exactly 12 strobes total.
- rst_n low for 1 cycle after the 3rd strobe → all outputs 0 next cycle, no EOF; a new request afterwards yields a complete, correct frame.
- tx_ready held high at request time → SOF withheld until tx_ready is low 2 cycles; the SOF strobe is then emitted.
